// File: rtl/channel_arbiter.sv
// channel_arbiter: round-robin sharing of one channel subchannel between NUM_REQ host requesters.
// Optional macro CHANNEL_ARB_TIMEOUT_EN adds a busy watchdog that pulses chan_stop once per operation.
module channel_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int START_WAIT     = 8,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_command,
    output logic                 done_valid,
    output logic [ID_W-1:0]      done_id,
    output logic [1:0]           done_cc,
    output logic [7:0]           done_status,
    output logic                 done_status_seen,
    output logic                 done_timed_out,
    output logic [7:0]           chan_addr,
    output logic [7:0]           chan_command,
    output logic                 chan_start,
    output logic                 chan_stop,
    input  logic                 chan_active,
    input  logic [1:0]           chan_condition_code,
    input  logic [7:0]           chan_status_tdata,
    input  logic                 chan_status_tvalid,
    input  logic                 chan_request,
    output logic                 attention
);
    localparam int WW = $clog2(START_WAIT + 1);

    typedef enum logic [2:0] {IDLE, ARB, START, WAIT_ACT, BUSY, DONE} state_t;

    state_t          state;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] win;
    logic [WW-1:0]   wcnt;
    logic [7:0]      status;
    logic            status_seen;
    logic            timed_out;
`ifdef CHANNEL_ARB_TIMEOUT_EN
    logic [31:0]     tcnt;
`endif

    if (ID_W != $clog2(NUM_REQ) || START_WAIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("channel_arbiter: ID_W must equal clog2(NUM_REQ) and wait limits must be positive");
    end

    // Winner: first requesting index after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx = last;
        win = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(last) + i) % NUM_REQ);
            if (req_valid[idx]) win = idx;
        end
    end

    // Operation sequencer: arbitrate, start the channel, supervise it and report completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            last             <= ID_W'(NUM_REQ - 1);
            wcnt             <= '0;
            status           <= '0;
            status_seen      <= 1'b0;
            timed_out        <= 1'b0;
            req_ready        <= '0;
            done_valid       <= 1'b0;
            done_id          <= '0;
            done_cc          <= '0;
            done_status      <= '0;
            done_status_seen <= 1'b0;
            done_timed_out   <= 1'b0;
            chan_addr        <= '0;
            chan_command     <= '0;
            chan_start       <= 1'b0;
            chan_stop        <= 1'b0;
            attention        <= 1'b0;
`ifdef CHANNEL_ARB_TIMEOUT_EN
            tcnt             <= '0;
`endif
        end else begin
            req_ready  <= '0;
            done_valid <= 1'b0;
            chan_start <= 1'b0;
            chan_stop  <= 1'b0;
            case (state)
                IDLE: begin
                    attention <= chan_request;
                    if (|req_valid && !chan_active) state <= ARB;
                end
                ARB: begin
                    if (|req_valid) begin
                        req_ready    <= NUM_REQ'(1) << win;
                        chan_addr    <= 8'(req_addr >> {win, 3'b000});
                        chan_command <= 8'(req_command >> {win, 3'b000});
                        last         <= win;
                        status       <= '0;
                        status_seen  <= 1'b0;
                        timed_out    <= 1'b0;
                        state        <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    chan_start <= 1'b1;
                    wcnt       <= '0;
                    state      <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (chan_active) begin
                        state <= BUSY;
`ifdef CHANNEL_ARB_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end else if (wcnt == WW'(START_WAIT - 1)) begin
                        done_valid       <= 1'b1;
                        done_id          <= last;
                        done_cc          <= 2'd2;
                        done_status      <= status;
                        done_status_seen <= status_seen;
                        done_timed_out   <= timed_out;
                        state            <= DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (chan_status_tvalid) begin
                        status      <= chan_status_tdata;
                        status_seen <= 1'b1;
                    end
                    if (!chan_active) begin
                        done_valid       <= 1'b1;
                        done_id          <= last;
                        done_cc          <= chan_condition_code;
                        done_status      <= chan_status_tvalid ? chan_status_tdata : status;
                        done_status_seen <= status_seen | chan_status_tvalid;
                        done_timed_out   <= timed_out;
                        state            <= DONE;
                    end
`ifdef CHANNEL_ARB_TIMEOUT_EN
                    else if (!timed_out) begin
                        if (tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                            chan_stop <= 1'b1;
                            timed_out <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
`endif
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_channel_arbiter.sv
// tb_channel_arbiter: vector table, hand sequences and randomized operations against a round-robin model.
module tb_channel_arbiter;
    localparam int N  = 4;
    localparam int SW = 8;
    localparam int TO = 100;
`ifdef CHANNEL_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_addr;
    logic [8*N-1:0] req_command;
    logic           done_valid;
    logic [1:0]     done_id;
    logic [1:0]     done_cc;
    logic [7:0]     done_status;
    logic           done_status_seen;
    logic           done_timed_out;
    logic [7:0]     chan_addr;
    logic [7:0]     chan_command;
    logic           chan_start;
    logic           chan_stop;
    logic           chan_active;
    logic [1:0]     chan_condition_code;
    logic [7:0]     chan_status_tdata;
    logic           chan_status_tvalid;
    logic           chan_request;
    logic           attention;

    int checks   = 0;
    int failures = 0;
    int rr_last  = N - 1;
    logic [7:0] a_addr [N];
    logic [7:0] a_cmd  [N];

    typedef struct {
        logic [N-1:0] mask;
        int           id;
        int           len;
        int           mode;
        logic [7:0]   sb;
        logic [1:0]   cc;
        logic [1:0]   ecc;
        bit           eseen;
        logic [7:0]   est;
    } vec_t;

    vec_t tbl [13];

    channel_arbiter #(.NUM_REQ(N), .ID_W(2), .START_WAIT(SW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_command(req_command), .done_valid(done_valid),
        .done_id(done_id), .done_cc(done_cc), .done_status(done_status),
        .done_status_seen(done_status_seen), .done_timed_out(done_timed_out),
        .chan_addr(chan_addr), .chan_command(chan_command), .chan_start(chan_start),
        .chan_stop(chan_stop), .chan_active(chan_active),
        .chan_condition_code(chan_condition_code), .chan_status_tdata(chan_status_tdata),
        .chan_status_tvalid(chan_status_tvalid), .chan_request(chan_request),
        .attention(attention)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // mode: 0 no status, 1 junk byte first then sb in last active cycle, 2 sb in the falling cycle
    task automatic op(input logic [N-1:0] mask, input int eid, input int len, input int mode,
                      input logic [7:0] sb, input logic [1:0] cc, input logic [1:0] ecc,
                      input bit eseen, input logic [7:0] est, input bit eto);
        int n;
        int stops;
        int stop_at;
        bit bad;
        req_valid = mask;
        for (int i = 0; i < N; i++) begin
            req_addr[8*i +: 8]    = a_addr[i];
            req_command[8*i +: 8] = a_cmd[i];
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 30);
        chk("grant", 32'(req_ready), 32'(1) << eid);
        if (req_ready == '0) return;
        rr_last = eid;
        @(negedge clk);
        chk("start", 32'({chan_start, chan_active, chan_addr, chan_command}),
            32'({1'b1, 1'b0, a_addr[eid], a_cmd[eid]}));
        if (len == 0) begin
            n = 0;
            while (!done_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("dead_latency", n, SW);
        end else begin
            stops = 0;
            stop_at = -1;
            bad = 1'b0;
            chan_condition_code = ~cc;
            for (int k = 0; k < len; k++) begin
                chan_active = 1'b1;
                chan_status_tvalid = (mode == 1 && (k == 0 || k == len - 1));
                chan_status_tdata = (mode == 1 && k == 0) ? 8'hAA : sb;
                @(negedge clk);
                if (chan_stop) begin
                    stops++;
                    stop_at = k;
                end
                if (chan_start || req_ready != '0 || done_valid ||
                    chan_addr != a_addr[eid] || chan_command != a_cmd[eid]) bad = 1'b1;
            end
            chan_active = 1'b0;
            chan_condition_code = cc;
            chan_status_tvalid = (mode == 2);
            chan_status_tdata = sb;
            @(negedge clk);
            chan_status_tvalid = 1'b0;
            chk("busy_quiet", 32'(bad), 0);
            chk("stop_count", stops, eto ? 1 : 0);
            if (eto) chk("stop_cycle", stop_at, TO);
            chk("fall_to_done", 32'(done_valid), 1);
        end
        chk("done_fields", 32'({done_valid, done_id, done_cc, done_status, done_status_seen, done_timed_out}),
            32'({1'b1, 2'(eid), ecc, est, eseen, eto}));
        @(negedge clk);
        chk("done_pulse", 32'({done_valid, chan_addr, chan_command}), 32'({1'b0, a_addr[eid], a_cmd[eid]}));
    endtask

    initial begin
        int n;
        bit bad;
        logic [N-1:0] m;
        int w;
        int len;
        int mode;
        logic [7:0] sb;
        logic [1:0] cc;
        a_addr = '{8'h10, 8'h21, 8'h40, 8'h53};
        a_cmd  = '{8'h01, 8'h03, 8'h02, 8'h07};
        tbl[0]  = '{4'b0100, 2, 4, 1, 8'h0C, 2'd0, 2'd0, 1'b1, 8'h0C};
        tbl[1]  = '{4'b1000, 3, 2, 2, 8'h55, 2'd1, 2'd1, 1'b1, 8'h55};
        tbl[2]  = '{4'b1111, 0, 1, 0, 8'h99, 2'd0, 2'd0, 1'b0, 8'h00};
        tbl[3]  = '{4'b1111, 1, 3, 1, 8'hA1, 2'd0, 2'd0, 1'b1, 8'hA1};
        tbl[4]  = '{4'b1111, 2, 2, 2, 8'h12, 2'd2, 2'd2, 1'b1, 8'h12};
        tbl[5]  = '{4'b1111, 3, 5, 0, 8'h66, 2'd1, 2'd1, 1'b0, 8'h00};
        tbl[6]  = '{4'b1111, 0, 1, 2, 8'hFF, 2'd0, 2'd0, 1'b1, 8'hFF};
        tbl[7]  = '{4'b1111, 1, 6, 1, 8'h33, 2'd3, 2'd3, 1'b1, 8'h33};
        tbl[8]  = '{4'b1111, 2, 2, 0, 8'h44, 2'd0, 2'd0, 1'b0, 8'h00};
        tbl[9]  = '{4'b1111, 3, 3, 2, 8'h77, 2'd1, 2'd1, 1'b1, 8'h77};
        tbl[10] = '{4'b0010, 1, 3, 0, 8'h00, 2'd3, 2'd3, 1'b0, 8'h00};
        tbl[11] = '{4'b0101, 2, 0, 0, 8'h00, 2'd0, 2'd2, 1'b0, 8'h00};
        tbl[12] = '{4'b0101, 0, 2, 0, 8'h00, 2'd0, 2'd0, 1'b0, 8'h00};

        reset_n = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_command = '0;
        chan_active = 1'b0;
        chan_condition_code = '0;
        chan_status_tdata = '0;
        chan_status_tvalid = 1'b0;
        chan_request = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_done", 32'({req_ready, done_valid, done_id, done_cc, done_status, done_status_seen, done_timed_out}), 0);
        chk("reset_chan", 32'({chan_addr, chan_command, chan_start, chan_stop, attention}), 0);
        reset_n = 1'b1;
        @(negedge clk);

        chan_request = 1'b1;
        @(negedge clk);
        chk("attention_set", 32'(attention), 1);
        chan_request = 1'b0;
        @(negedge clk);
        chk("attention_clr", 32'(attention), 0);

        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (req_ready != '0 || chan_start) bad = 1'b1;
        end
        chk("arb_drop_no_grant", 32'(bad), 0);

        for (int t = 0; t < 13; t++)
            op(tbl[t].mask, tbl[t].id, tbl[t].len, tbl[t].mode, tbl[t].sb, tbl[t].cc,
               tbl[t].ecc, tbl[t].eseen, tbl[t].est, 1'b0);

        op(4'b0001, 0, 300, 0, 8'h00, 2'd0, 2'd0, 1'b0, 8'h00, TO_EN);

        for (int t = 0; t < 30; t++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                a_addr[i] = 8'($urandom);
                a_cmd[i]  = 8'($urandom);
            end
            w = -1;
            for (int i = 1; i <= N; i++)
                if (w < 0 && m[(rr_last + i) % N]) w = (rr_last + i) % N;
            len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
            mode = int'($urandom_range(0, 2));
            if (mode == 1 && len < 2) mode = 2;
            sb = 8'($urandom);
            cc = 2'($urandom);
            if (len == 0) op(m, w, 0, 0, sb, cc, 2'd2, 1'b0, 8'h00, 1'b0);
            else op(m, w, len, mode, sb, cc, cc, mode != 0, (mode != 0) ? sb : 8'h00, 1'b0);
        end

        op(4'b0001, 0, 2, 0, 8'h00, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0);
        req_valid = 4'b0110;
        n = 0;
        while (!chan_start && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rst_seq_start", 32'({chan_start, chan_addr}), 32'({1'b1, a_addr[1]}));
        chan_active = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        req_valid = 4'b0111;
        @(negedge clk);
        chk("midop_reset_done", 32'({req_ready, done_valid, done_id, done_cc, done_status, done_status_seen, done_timed_out}), 0);
        chk("midop_reset_chan", 32'({chan_addr, chan_command, chan_start, chan_stop, attention}), 0);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (req_ready != '0 || done_valid) bad = 1'b1;
        end
        chan_active = 1'b0;
        @(negedge clk);
        if (done_valid) bad = 1'b1;
        chk("midop_reset_quiet", 32'(bad), 0);
        rr_last = N - 1;
        op(4'b0111, 0, 2, 2, 8'h5A, 2'd1, 2'd1, 1'b1, 8'h5A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
